// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : dmem_arb_pkg
// Brief  : Shared types and default limits for the data-memory arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    typedef enum logic [0:0] {
        ARB_FREE      = 1'b0,
        ARB_HOST_LOCK = 1'b1
    } arb_state_t;

    localparam int c_HOST_MAX_WAIT = 4;
    localparam int c_LOCK_MAX      = 8;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module : sat_counter
// Brief  : Up-counter that saturates at MAX, with clear priority over increment.
// Rev    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int MAX = 4,
    parameter int W   = (MAX < 1) ? 1 : $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [W-1:0] c_MAX = W'(MAX);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != c_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // MAX = 0 leaves the count pinned at zero, so at_max is permanently set.
    assign at_max = (r_count == c_MAX);

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : dmem_arbiter
// Brief  : Core/host arbiter for the single-port data memory (core priority,
//          bounded host wait, locked host bursts with periodic core slot).
// Rev    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW            = 8,
    parameter int DW            = 8,
    parameter int HOST_MAX_WAIT = c_HOST_MAX_WAIT,
    parameter int LOCK_MAX      = c_LOCK_MAX
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          core_stall,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic          host_lock,
    output logic          host_gnt,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr_en,
    output logic [DW-1:0] mem_dat_in,
    input  logic [DW-1:0] mem_dat_out
);

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    logic          w_host_gnt;
    logic          w_force_core;
    logic          w_wait_inc;
    logic          w_wait_clr;
    logic          w_wait_max;
    logic          w_lock_inc;
    logic          w_lock_clr;
    logic          w_lock_max;
    logic [DW-1:0] r_host_rdata;
    logic          r_host_rvalid;

    sat_counter #(.MAX(HOST_MAX_WAIT)) u_wait_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc    (w_wait_inc),
        .clr    (w_wait_clr),
        .at_max (w_wait_max)
    );

    sat_counter #(.MAX(LOCK_MAX)) u_lock_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc    (w_lock_inc),
        .clr    (w_lock_clr),
        .at_max (w_lock_max)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ARB_FREE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_host_gnt   = 1'b0;
        w_force_core = 1'b0;
        w_wait_inc   = 1'b0;
        w_wait_clr   = 1'b1;
        w_lock_inc   = 1'b0;
        w_lock_clr   = 1'b0;
        case (r_state)
            ARB_FREE: begin
                w_host_gnt = host_req && (!core_req || w_wait_max);
                w_wait_inc = host_req && !w_host_gnt;
                w_wait_clr = !w_wait_inc;
                // lock count sits at zero while free, so one increment loads 1
                if (w_host_gnt && host_lock) begin
                    w_state_nxt = ARB_HOST_LOCK;
                    w_lock_inc  = 1'b1;
                end else begin
                    w_lock_clr = 1'b1;
                end
            end
            ARB_HOST_LOCK: begin
                w_force_core = w_lock_max && core_req;
                w_host_gnt   = host_req && !w_force_core;
                if (!host_req || (w_host_gnt && !host_lock)) begin
                    w_state_nxt = ARB_FREE;
                    w_lock_clr  = 1'b1;
                end else if (w_force_core) begin
                    w_lock_clr = 1'b1;
                end else begin
                    w_lock_inc = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ARB_FREE;
            end
        endcase
        if (reset) begin
            w_host_gnt = 1'b0;
        end
    end

    assign host_gnt   = w_host_gnt;
    assign core_stall = core_req && w_host_gnt;
    assign core_rdata = mem_dat_out;
    assign mem_addr   = w_host_gnt ? host_addr  : core_addr;
    assign mem_dat_in = w_host_gnt ? host_wdata : core_wdata;
    // reset gating also kills a write that was in flight when reset arrived
    assign mem_wr_en  = !reset && (w_host_gnt ? host_we : (core_req && core_we));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_host_rdata  <= '0;
            r_host_rvalid <= 1'b0;
        end else begin
            r_host_rvalid <= w_host_gnt && !host_we;
            if (w_host_gnt && !host_we) begin
                r_host_rdata <= mem_dat_out;
            end
        end
    end

    assign host_rdata  = r_host_rdata;
    assign host_rvalid = r_host_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_dmem_arbiter
// Brief  : Self-checking bench for dmem_arbiter (vector table, directed
//          corner sequences, randomized run against a behavioural model).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int c_WAIT = 4;
    localparam int c_LMAX = 8;

    logic       clk = 1'b0;
    logic       reset, mem_init;
    logic       core_req, core_we, host_req, host_we, host_lock;
    logic [7:0] core_addr, core_wdata, host_addr, host_wdata;
    logic [7:0] core_rdata, host_rdata, mem_addr, mem_dat_in, mem_dat_out;
    logic       core_stall, host_gnt, host_rvalid, mem_wr_en;
    logic [7:0] z_core_rdata, z_host_rdata, z_mem_addr, z_mem_dat_in, z_mem_dat_out;
    logic       z_core_stall, z_host_gnt, z_host_rvalid, z_mem_wr_en;
    logic [7:0] mem  [256];
    logic [7:0] mem0 [256];
    logic [7:0] ref_mem [256];
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) begin
                mem[i]  <= '0;
                mem0[i] <= '0;
            end
        end else begin
            if (mem_wr_en)   mem[mem_addr]    <= mem_dat_in;
            if (z_mem_wr_en) mem0[z_mem_addr] <= z_mem_dat_in;
        end
    end
    assign mem_dat_out   = mem[mem_addr];
    assign z_mem_dat_out = mem0[z_mem_addr];

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_lock(host_lock), .host_gnt(host_gnt),
        .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_dat_in(mem_dat_in),
        .mem_dat_out(mem_dat_out)
    );

    dmem_arbiter #(.HOST_MAX_WAIT(0)) dut0 (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(z_core_rdata), .core_stall(z_core_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_lock(host_lock), .host_gnt(z_host_gnt),
        .host_rdata(z_host_rdata), .host_rvalid(z_host_rvalid),
        .mem_addr(z_mem_addr), .mem_wr_en(z_mem_wr_en), .mem_dat_in(z_mem_dat_in),
        .mem_dat_out(z_mem_dat_out)
    );

    typedef struct {
        logic creq, cwe; logic [7:0] caddr, cwd;
        logic hreq, hwe; logic [7:0] haddr, hwd;
        logic e_gnt, e_stall, e_we; logic [7:0] e_addr, e_crd;
        logic e_rv; logic [7:0] e_hrd;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0; host_lock = 0;
    endtask

    task automatic pulse_reset();
        reset = 1; tick(); reset = 0;
    endtask

    // Behavioural model state for the random phase
    bit         m_locked, m_rv, m_gnt, m_force, m_stall, m_we;
    int         m_wait, m_lock;
    logic [7:0] m_hrd, m_addr, m_din;
    bit         m_pending;

    initial begin
        int beat;
        tbl[0] = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b1,8'h20,8'h5A, 1'b1,1'b0,1'b1,8'h20,8'h00, 1'b0,8'h00};
        tbl[1] = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b1,8'h10,8'h33, 1'b1,1'b0,1'b1,8'h10,8'h00, 1'b0,8'h00};
        tbl[2] = '{1'b1,1'b0,8'h10,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h10,8'h33, 1'b0,8'h00};
        tbl[3] = '{1'b1,1'b1,8'h30,8'h77, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b1,8'h30,8'h00, 1'b0,8'h00};
        tbl[4] = '{1'b1,1'b0,8'h30,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h30,8'h77, 1'b0,8'h00};
        tbl[5] = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,8'h20,8'h00, 1'b1,1'b0,1'b0,8'h20,8'h5A, 1'b0,8'h00};
        tbl[6] = '{1'b1,1'b0,8'h20,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h20,8'h5A, 1'b1,8'h5A};
        tbl[7] = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,8'h5A};

        // Reset state with every request asserted
        reset = 1; mem_init = 1; drive_idle();
        core_req = 1; core_we = 1; host_req = 1; host_we = 1; host_lock = 1;
        @(negedge clk);
        chk("rst_gnt", host_gnt, 0);
        chk("rst_stall", core_stall, 0);
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_rvalid", host_rvalid, 0);
        chk("rst_hrdata", host_rdata, 0);
        tick(); tick();
        reset = 0; mem_init = 0; drive_idle();

        for (int r = 0; r < 8; r++) begin
            core_req = tbl[r].creq; core_we = tbl[r].cwe;
            core_addr = tbl[r].caddr; core_wdata = tbl[r].cwd;
            host_req = tbl[r].hreq; host_we = tbl[r].hwe;
            host_addr = tbl[r].haddr; host_wdata = tbl[r].hwd; host_lock = 0;
            @(negedge clk);
            chk($sformatf("row%0d_gnt", r), host_gnt, tbl[r].e_gnt);
            chk($sformatf("row%0d_stall", r), core_stall, tbl[r].e_stall);
            chk($sformatf("row%0d_wr_en", r), mem_wr_en, tbl[r].e_we);
            chk($sformatf("row%0d_addr", r), mem_addr, tbl[r].e_addr);
            chk($sformatf("row%0d_crdata", r), core_rdata, tbl[r].e_crd);
            chk($sformatf("row%0d_rvalid", r), host_rvalid, tbl[r].e_rv);
            chk($sformatf("row%0d_hrdata", r), host_rdata, tbl[r].e_hrd);
            tick();
        end

        // Host read behind a busy core: forced grant after HOST_MAX_WAIT
        drive_idle();
        core_req = 1; core_addr = 8'h40; host_req = 1; host_addr = 8'h20;
        for (int c = 1; c <= c_WAIT + 1; c++) begin
            @(negedge clk);
            chk($sformatf("wait_gnt_c%0d", c), host_gnt, int'(c == c_WAIT + 1));
            chk($sformatf("wait_stall_c%0d", c), core_stall, int'(c == c_WAIT + 1));
            tick();
        end
        host_req = 0;
        @(negedge clk);
        chk("wait_rvalid", host_rvalid, 1);
        chk("wait_hrdata", host_rdata, 8'h5A);
        tick();
        @(negedge clk);
        chk("wait_rvalid_pulse", host_rvalid, 0);
        tick();

        // Locked 12-beat write burst with the core requesting throughout
        drive_idle();
        core_req = 1; core_addr = 8'h50;
        beat = 0;
        host_req = 1; host_we = 1; host_lock = 1; host_addr = 8'h80; host_wdata = 8'h00;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            chk($sformatf("burst_gnt_c%0d", c), host_gnt,
                int'((c >= 5 && c <= 12) || (c >= 14 && c <= 17)));
            chk($sformatf("burst_stall_c%0d", c), core_stall,
                int'((c >= 5 && c <= 12) || (c >= 14 && c <= 17)));
            if (host_gnt) beat++;
            tick();
            host_addr = 8'h80 + 8'(beat); host_wdata = 8'(beat);
            host_lock = (beat < 11); host_req = (beat < 12);
        end
        chk("burst_beats", beat, 12);
        for (int k = 0; k < 12; k++) chk($sformatf("burst_mem%0d", k), mem[8'h80 + k], k);

        // Reset in the middle of a locked burst
        drive_idle();
        beat = 0;
        host_req = 1; host_we = 1; host_lock = 1; host_addr = 8'hA0; host_wdata = 8'hE0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("rb_gnt_b%0d", c), host_gnt, 1);
            tick();
            host_addr = 8'hA1 + 8'(c); host_wdata = 8'hE1 + 8'(c);
        end
        core_req = 1; core_we = 1; core_addr = 8'h60; core_wdata = 8'h99;
        #1 reset = 1;
        @(negedge clk);
        chk("rb_rst_gnt", host_gnt, 0);
        chk("rb_rst_wr_en", mem_wr_en, 0);
        chk("rb_rst_stall", core_stall, 0);
        tick();
        reset = 0;
        @(negedge clk);
        chk("rb_post_gnt", host_gnt, 0);
        chk("rb_post_stall", core_stall, 0);
        chk("rb_post_wr_en", mem_wr_en, 1);
        chk("rb_post_addr", mem_addr, 8'h60);
        tick();
        drive_idle();
        @(negedge clk);
        chk("rb_mem_beat3", mem[8'hA2], 0);
        chk("rb_mem_beat1", mem[8'hA0], 8'hE0);
        chk("rb_mem_core", mem[8'h60], 8'h99);
        tick();

        // HOST_MAX_WAIT = 0: host always wins, core store never lands
        pulse_reset();
        core_req = 1; core_we = 1; core_addr = 8'h70; core_wdata = 8'hC3;
        host_req = 1; host_we = 0; host_lock = 0; host_addr = 8'h05;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("hw0_gnt_c%0d", c), z_host_gnt, 1);
            chk($sformatf("hw0_stall_c%0d", c), z_core_stall, 1);
            chk($sformatf("hw0_wr_en_c%0d", c), z_mem_wr_en, 0);
            if (c > 0) chk($sformatf("hw0_rvalid_c%0d", c), z_host_rvalid, 1);
            tick();
            host_addr = 8'($urandom_range(0, 255));
        end
        drive_idle();
        @(negedge clk);
        chk("hw0_mem_untouched", mem0[8'h70], 0);
        tick();

        // Randomized run against the behavioural model
        pulse_reset();
        drive_idle();
        tick();
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        m_locked = 0; m_wait = 0; m_lock = 0; m_rv = 0; m_hrd = 0; m_pending = 0;
        for (int n = 0; n < 600; n++) begin
            if (!m_pending) begin
                host_req   = ($urandom_range(0, 99) < 55);
                host_we    = $urandom_range(0, 1) == 1;
                host_addr  = 8'($urandom_range(0, 15));
                host_wdata = 8'($urandom_range(0, 255));
                host_lock  = ($urandom_range(0, 99) < 60);
            end
            core_req   = ($urandom_range(0, 99) < 60);
            core_we    = $urandom_range(0, 1) == 1;
            core_addr  = 8'($urandom_range(0, 15));
            core_wdata = 8'($urandom_range(0, 255));
            @(negedge clk);
            if (m_locked) begin
                m_force = (m_lock == c_LMAX) && core_req;
                m_gnt   = host_req && !m_force;
            end else begin
                m_force = 0;
                m_gnt   = host_req && (!core_req || m_wait == c_WAIT);
            end
            m_stall = core_req && m_gnt;
            m_we    = m_gnt ? host_we : (core_req && core_we);
            m_addr  = m_gnt ? host_addr : core_addr;
            m_din   = m_gnt ? host_wdata : core_wdata;
            chk($sformatf("rnd%0d_gnt", n), host_gnt, m_gnt);
            chk($sformatf("rnd%0d_stall", n), core_stall, m_stall);
            chk($sformatf("rnd%0d_wr_en", n), mem_wr_en, m_we);
            chk($sformatf("rnd%0d_addr", n), mem_addr, m_addr);
            if (m_we) chk($sformatf("rnd%0d_din", n), mem_dat_in, m_din);
            if (core_req && !m_stall) chk($sformatf("rnd%0d_crdata", n), core_rdata, ref_mem[core_addr]);
            chk($sformatf("rnd%0d_rvalid", n), host_rvalid, m_rv);
            chk($sformatf("rnd%0d_hrdata", n), host_rdata, m_hrd);
            m_rv = m_gnt && !host_we;
            if (m_rv) m_hrd = ref_mem[host_addr];
            if (m_we) ref_mem[m_addr] = m_din;
            if (!m_locked) begin
                m_wait = (host_req && !m_gnt) ? ((m_wait < c_WAIT) ? m_wait + 1 : c_WAIT) : 0;
                if (m_gnt && host_lock) begin
                    m_locked = 1; m_lock = 1;
                end
            end else begin
                m_wait = 0;
                if (!host_req || (m_gnt && !host_lock)) begin
                    m_locked = 0; m_lock = 0;
                end else if (m_force) begin
                    m_lock = 0;
                end else begin
                    m_lock = (m_lock < c_LMAX) ? m_lock + 1 : c_LMAX;
                end
            end
            m_pending = host_req && !m_gnt;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
